// File: rtl/branch_resolve_unit.sv
// Pipelined RV32I/RV64I branch resolver: condition decode, target add, mispredict flag.
// Optional BRU_STATS_EN adds saturating taken/mispredict counters on the output handshake.
module branch_resolve_unit #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [2:0]      in_funct3,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_pred_taken,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_taken,
  output logic [XLEN-1:0] out_target,
  output logic            out_mispredict,
  output logic            out_illegal
`ifdef BRU_STATS_EN
  ,
  input  logic            stat_clr,
  output logic [31:0]     stat_taken_cnt,
  output logic [31:0]     stat_mispredict_cnt
`endif
);

  // Illegal funct3 (010/011) falls to default and never resolves taken.
  function automatic logic f_taken(input logic [2:0] f3, input logic eq,
                                   input logic lt, input logic ltu);
    case (f3)
      3'b000:  return eq;
      3'b001:  return !eq;
      3'b100:  return lt;
      3'b101:  return !lt;
      3'b110:  return ltu;
      3'b111:  return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  logic            w_eq, w_lt, w_ltu;
  logic [XLEN-1:0] w_tgt;

  assign w_eq  = (in_rs1 == in_rs2);
  assign w_lt  = ($signed(in_rs1) < $signed(in_rs2));
  assign w_ltu = (in_rs1 < in_rs2);
  assign w_tgt = in_pc + in_imm;

  generate
    if (STAGES == 1) begin : g_s1
      logic            r_vld, r_taken, r_mis, r_ill;
      logic [XLEN-1:0] r_tgt;
      logic            w_tk;

      assign w_tk     = f_taken(in_funct3, w_eq, w_lt, w_ltu);
      assign in_ready = !r_vld || out_ready;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_vld   <= 1'b0;
          r_taken <= 1'b0;
          r_mis   <= 1'b0;
          r_ill   <= 1'b0;
          r_tgt   <= '0;
        end else if (flush) begin
          r_vld <= 1'b0;
        end else if (in_ready) begin
          r_vld <= in_valid;
          if (in_valid) begin
            r_taken <= w_tk;
            r_tgt   <= w_tgt;
            r_mis   <= w_tk ^ in_pred_taken;
            r_ill   <= (in_funct3[2:1] == 2'b01);
          end
        end
      end

      assign out_valid      = r_vld;
      assign out_taken      = r_taken;
      assign out_target     = r_tgt;
      assign out_mispredict = r_mis;
      assign out_illegal    = r_ill;
    end else if (STAGES == 2) begin : g_s2
      logic [2:1]      r_vld_pipe;
      logic            r_eq, r_lt, r_ltu, r_pred;
      logic [2:0]      r_f3;
      logic [XLEN-1:0] r_tgt1, r_tgt2;
      logic            r_taken, r_mis, r_ill;
      logic            w_s2_ld, w_tk2;

      assign w_s2_ld  = !r_vld_pipe[2] || out_ready;
      assign in_ready = !r_vld_pipe[1] || w_s2_ld;
      assign w_tk2    = f_taken(r_f3, r_eq, r_lt, r_ltu);

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_vld_pipe <= '0;
          r_eq       <= 1'b0;
          r_lt       <= 1'b0;
          r_ltu      <= 1'b0;
          r_pred     <= 1'b0;
          r_f3       <= '0;
          r_tgt1     <= '0;
          r_tgt2     <= '0;
          r_taken    <= 1'b0;
          r_mis      <= 1'b0;
          r_ill      <= 1'b0;
        end else if (flush) begin
          r_vld_pipe <= '0;
        end else begin
          if (w_s2_ld) begin
            r_vld_pipe[2] <= r_vld_pipe[1];
            if (r_vld_pipe[1]) begin
              r_taken <= w_tk2;
              r_tgt2  <= r_tgt1;
              r_mis   <= w_tk2 ^ r_pred;
              r_ill   <= (r_f3[2:1] == 2'b01);
            end
          end
          if (in_ready) begin
            r_vld_pipe[1] <= in_valid;
            if (in_valid) begin
              r_eq   <= w_eq;
              r_lt   <= w_lt;
              r_ltu  <= w_ltu;
              r_f3   <= in_funct3;
              r_pred <= in_pred_taken;
              r_tgt1 <= w_tgt;
            end
          end
        end
      end

      assign out_valid      = r_vld_pipe[2];
      assign out_taken      = r_taken;
      assign out_target     = r_tgt2;
      assign out_mispredict = r_mis;
      assign out_illegal    = r_ill;
    end else begin : g_bad
      $error("branch_resolve_unit: STAGES must be 1 or 2");
    end
  endgenerate

`ifdef BRU_STATS_EN
  logic [31:0] r_taken_cnt, r_mis_cnt;
  logic        w_hs;

  // A handshake coincident with flush still counts: the item was consumed.
  assign w_hs = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || stat_clr) begin
      r_taken_cnt <= '0;
      r_mis_cnt   <= '0;
    end else if (w_hs) begin
      if (out_taken && r_taken_cnt != '1)    r_taken_cnt <= r_taken_cnt + 32'd1;
      if (out_mispredict && r_mis_cnt != '1) r_mis_cnt   <= r_mis_cnt + 32'd1;
    end
  end

  assign stat_taken_cnt      = r_taken_cnt;
  assign stat_mispredict_cnt = r_mis_cnt;
`endif

endmodule
